nn_result_uart_tx: RTL and testbench

Transmit side of the neural-net result path. On a start pulse it captures the Neural_net outputs (izlaz_1, izlaz_2, indikator_1, indikator_2) and sends them as one fixed framed packet over a UART line (8N1, LSB first). The sample selection and controller logic feeds the net. This block returns the classification result to a host or monitor.

---
 rtl/nn_tx_pkg.sv | 23 ++
 rtl/uart_tx_byte.sv | 88 ++++++++
 rtl/nn_result_uart_tx.sv | 120 ++++++++++++
 tb/tb_nn_result_uart_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_tx_pkg.sv
// Shared constants and state encoding for the neural-net result UART transmitter.
// Build option: NN_TX_CHECKSUM_EN appends an XOR checksum byte to every frame.
package nn_tx_pkg;

  localparam logic [7:0] NN_TX_HEADER = 8'hA5;

`ifdef NN_TX_CHECKSUM_EN
  localparam int NN_TX_FRAME_BYTES = 7;
`else
  localparam int NN_TX_FRAME_BYTES = 6;
`endif

  localparam int NN_TX_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer, LSB first. A load during the final stop-bit cycle
// chains the next byte with no idle gap. Unaffected by NN_TX_CHECKSUM_EN.
module uart_tx_byte
  import nn_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e      state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           baud_end;

  assign baud_end = (baud_q == BAUD_LAST);
  assign ready_o  = (state_q == IDLE) || ((state_q == STOP) && baud_end);
  assign tx_o     = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      START: if (baud_end) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
      end
      DATA: if (baud_end) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 1'b1;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      STOP: if (baud_end) begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
      default: ;
    endcase
    // A load overrides the stop-to-idle step so bytes run back-to-back.
    if (ready_o && load_i) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = data_i;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/nn_result_uart_tx.sv
// Captures the net result on start and sends it as one framed UART packet.
// Build option: NN_TX_CHECKSUM_EN appends B6 = XOR of B0..B5.
module nn_result_uart_tx
  import nn_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] izlaz_1,
  input  logic [15:0] izlaz_2,
  input  logic        indikator_1,
  input  logic        indikator_2,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [NN_TX_IDX_W-1:0] LAST_IDX = NN_TX_IDX_W'(NN_TX_FRAME_BYTES);

  // Frame-level states: IDLE, DATA (bytes streaming), DONE (one-cycle tail).
  tx_state_e              state_q, state_d;
  logic [NN_TX_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [1:0]             cap_ind_q, cap_ind_d;
  logic [15:0]            cap_iz1_q, cap_iz1_d;
  logic [15:0]            cap_iz2_q, cap_iz2_d;
  logic                   ser_ready;
  logic                   ser_load;
  logic [7:0]             ser_data;
  logic [7:0]             cur_byte;

`ifdef NN_TX_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = NN_TX_HEADER ^ {6'b0, cap_ind_q} ^ cap_iz1_q[15:8] ^ cap_iz1_q[7:0]
              ^ cap_iz2_q[15:8] ^ cap_iz2_q[7:0];
`endif

  always_comb begin
    cur_byte = NN_TX_HEADER;
    case (byte_idx_q)
      3'd1:    cur_byte = {6'b0, cap_ind_q};
      3'd2:    cur_byte = cap_iz1_q[15:8];
      3'd3:    cur_byte = cap_iz1_q[7:0];
      3'd4:    cur_byte = cap_iz2_q[15:8];
      3'd5:    cur_byte = cap_iz2_q[7:0];
`ifdef NN_TX_CHECKSUM_EN
      3'd6:    cur_byte = csum;
`endif
      default: cur_byte = NN_TX_HEADER;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    cap_ind_d  = cap_ind_q;
    cap_iz1_d  = cap_iz1_q;
    cap_iz2_d  = cap_iz2_q;
    ser_load   = 1'b0;
    ser_data   = NN_TX_HEADER;
    case (state_q)
      IDLE: if (start) begin
        // Header is constant, so B0 loads on the accepting edge itself.
        state_d    = DATA;
        ser_load   = 1'b1;
        ser_data   = NN_TX_HEADER;
        byte_idx_d = NN_TX_IDX_W'(1);
        cap_ind_d  = {indikator_2, indikator_1};
        cap_iz1_d  = izlaz_1;
        cap_iz2_d  = izlaz_2;
      end
      DATA: if (ser_ready) begin
        if (byte_idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          ser_load   = 1'b1;
          ser_data   = cur_byte;
          byte_idx_d = byte_idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        byte_idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      cap_ind_q  <= '0;
      cap_iz1_q  <= '0;
      cap_iz2_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      cap_ind_q  <= cap_ind_d;
      cap_iz1_q  <= cap_iz1_d;
      cap_iz2_q  <= cap_iz2_d;
    end
  end

  assign busy = (state_q == DATA);
  assign done = (state_q == DONE);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load_i (ser_load),
    .data_i (ser_data),
    .ready_o(ser_ready),
    .tx_o   (tx)
  );

endmodule

// File: tb/tb_nn_result_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a UART monitor decodes tx and compares.
module tb_nn_result_uart_tx;

  localparam int CPB = 4;
`ifdef NN_TX_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam int FRAME_CYC = NB * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] izlaz_1 = '0;
  logic [15:0] izlaz_2 = '0;
  logic        indikator_1 = 1'b0;
  logic        indikator_2 = 1'b0;
  logic        tx, busy, done;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  nn_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .izlaz_1    (izlaz_1),
    .izlaz_2    (izlaz_2),
    .indikator_1(indikator_1),
    .indikator_2(indikator_2),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive the inputs and queue the bytes the frame must carry.
  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic i1, input logic i2);
    logic [7:0] f [7];
    izlaz_1 = a; izlaz_2 = b; indikator_1 = i1; indikator_2 = i2;
    f[0] = 8'hA5; f[1] = {6'b0, i2, i1};
    f[2] = a[15:8]; f[3] = a[7:0]; f[4] = b[15:8]; f[5] = b[7:0];
    f[6] = f[0] ^ f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5];
    for (int i = 0; i < NB; i++) exp_q.push_back(f[i]);
  endtask

  // Decode one 8N1 byte; every clock of every bit must hold the same level.
  task automatic decode_byte();
    logic [9:0] bits;
    logic       stable;
    logic       s;
    logic [7:0] e;
    bits = '0;
    stable = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (rst) return;
        s = tx;
        if (c == 0) bits[b] = s;
        else if (s !== bits[b]) stable = 1'b0;
      end
    end
    check("bit_timing", {31'b0, stable}, 32'd1);
    check("stop_bit", {31'b0, bits[9]}, 32'd1);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_byte: got %h, required no byte", bits[8:1]);
    end else begin
      e = exp_q.pop_front();
      $display("rx byte %h (expected %h)", bits[8:1], e);
      check("rx_byte", {24'b0, bits[8:1]}, {24'b0, e});
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) decode_byte();
    end
  end

  // Start a frame, optionally poke inputs and start at busy cycle poke_at, measure busy/done.
  task automatic run_frame(input logic [15:0] a, input logic [15:0] b,
                           input logic i1, input logic i2, input int poke_at);
    int cnt;
    check("idle_tx_before", {31'b0, tx}, 32'd1);
    apply(a, b, i1, i2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("tx_start_edge", {31'b0, tx}, 32'd0);
    check("busy_rise", {31'b0, busy}, 32'd1);
    cnt = 1;
    for (int k = 0; k < FRAME_CYC + 20; k++) begin
      start = (cnt == poke_at);
      if (cnt == poke_at) izlaz_1 = 16'hFFFF;
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    start = 1'b0;
    check("busy_cycles", cnt, FRAME_CYC);
    check("done_pulse", {31'b0, done}, 32'd1);
    check("idle_tx_after", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check("done_single", {31'b0, done}, 32'd0);
  endtask

  task automatic wait_not_busy(output int cnt);
    cnt = 0;
    for (int k = 0; k < FRAME_CYC + 20; k++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
  endtask

  initial begin : stimulus
    int cnt;
    int done_seen;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame: A5 01 12 34 AB CD (+E4 checksum)
    run_frame(16'h1234, 16'hABCD, 1'b1, 1'b0, 0);

    // Input change and ignored start mid-frame
    run_frame(16'h1234, 16'hABCD, 1'b1, 1'b0, 50);
    repeat (100) @(negedge clk);
    check("no_second_busy", {31'b0, busy}, 32'd0);
    check("queue_drained", exp_q.size(), 0);

    // Reset during B3 data bits
    apply(16'h1234, 16'hABCD, 1'b1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (130) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_tx", {31'b0, tx}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_frame(16'h1234, 16'hABCD, 1'b1, 1'b0, 0);

    // Bit timing with B1 = 02 and zero payload
    run_frame(16'h0000, 16'h0000, 1'b0, 1'b1, 0);

    // Back-to-back: start on done is ignored, start one cycle later accepted
    repeat (3) @(negedge clk);
    apply(16'h5A0F, 16'h00FF, 1'b1, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_not_busy(cnt);
    check("b2b_busy_cycles", cnt, FRAME_CYC - 1);
    check("b2b_done", {31'b0, done}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    check("b2b_ignored_tx", {31'b0, tx}, 32'd1);
    check("b2b_ignored_busy", {31'b0, busy}, 32'd0);
    apply(16'hC3C3, 16'h8001, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_accept_tx", {31'b0, tx}, 32'd0);
    check("b2b_accept_busy", {31'b0, busy}, 32'd1);
    wait_not_busy(cnt);
    check("b2b2_busy_cycles", cnt, FRAME_CYC - 1);
    check("b2b2_done", {31'b0, done}, 32'd1);

    repeat (10) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
